gate_sequencer: RTL

Single-lane parking barrier controller that shares one gate between entry and exit requests. It registers the free-spot count derived from the 8 spot sensors (CH, 1 = occupied), refuses entry when the lot is full, and arbitrates simultaneous entry/exit requests round-robin. It sequences each request through open, vehicle-pass and close phases with timeout and guard timers. It sits between the spot sensors and the free-spot display and drives the barrier motor and status LEDs.

---
 rtl/gate_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/gate_sequencer.sv
// Purpose: single-lane parking barrier controller shared by entry and exit, with a round-robin tie-break.
// Latency: an eligible request in IDLE opens the gate one edge later; FREE follows CH one edge later.
// Backpressure: requests are level-held by the driver, ignored outside IDLE, and entry is refused while FULL.
//
// Ports:
//   CLK, RST_N      clock, synchronous active-low reset
//   CH[7:0]         spot sensors, 1 = occupied
//   REQ_IN/REQ_OUT  entry / exit request levels
//   PASS            loop sensor, 1 = vehicle under barrier
//   GATE_OPEN       barrier motor command
//   BUSY, DIR       sequence in progress; direction of current/last grant (0 entry, 1 exit)
//   DONE, ABORT     one-cycle pulses: vehicle passed / open phase timed out
//   FREE, FULL      registered free-spot count; FREE == 0
module gate_sequencer #(
  parameter int OPEN_TIMEOUT = 50_000_000,
  parameter int GUARD        = 5_000_000,
  parameter int TW           = 32
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] CH,
  input  logic       REQ_IN,
  input  logic       REQ_OUT,
  input  logic       PASS,
  output logic       GATE_OPEN,
  output logic       BUSY,
  output logic       DIR,
  output logic       DONE,
  output logic       ABORT,
  output logic [3:0] FREE,
  output logic       FULL
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OPEN  = 2'd1,
    S_HOLD  = 2'd2,
    S_CLOSE = 2'd3
  } state_t;

  localparam logic [TW-1:0] OPEN_LOAD  = TW'(OPEN_TIMEOUT - 1);
  localparam logic [TW-1:0] GUARD_LOAD = TW'(GUARD - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic          last_dir;      // direction of the most recent grant; reset to exit so entry wins the first tie
  logic          last_dir_nxt;
  logic          dir_nxt;
  logic          done_nxt;
  logic          abort_nxt;
  logic          gate_nxt;
  logic          busy_nxt;
  logic [3:0]    occupied;
  logic [3:0]    free_nxt;
  logic          entry_ok;
  logic          exit_ok;
  logic          grant_vld;
  logic          grant_dir;

  // Occupied-spot count; FREE is the registered complement out of 8.
  always_comb begin
    occupied = 4'd0;
    for (int i = 0; i < 8; i++) begin
      occupied = occupied + {3'b000, CH[i]};
    end
    free_nxt = 4'd8 - occupied;
  end

  assign FULL = (FREE == 4'd0);

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    last_dir_nxt = last_dir;
    dir_nxt      = DIR;
    done_nxt     = 1'b0;
    abort_nxt    = 1'b0;
    grant_vld    = 1'b0;
    grant_dir    = 1'b0;
    entry_ok     = REQ_IN & ~FULL;
    exit_ok      = REQ_OUT;

    case (state)
      S_IDLE: begin
        if (entry_ok && exit_ok) begin
          // Tie: serve whichever direction was not granted last.
          grant_vld = 1'b1;
          grant_dir = ~last_dir;
        end else if (entry_ok) begin
          grant_vld = 1'b1;
          grant_dir = 1'b0;
        end else if (exit_ok) begin
          grant_vld = 1'b1;
          grant_dir = 1'b1;
        end
        if (grant_vld) begin
          state_nxt    = S_OPEN;
          dir_nxt      = grant_dir;
          last_dir_nxt = grant_dir;
          timer_nxt    = OPEN_LOAD;
        end
      end
      S_OPEN: begin
        // A vehicle arriving on the final timeout cycle still wins over the abort.
        if (PASS) begin
          state_nxt = S_HOLD;
        end else if (timer == '0) begin
          state_nxt = S_CLOSE;
          abort_nxt = 1'b1;
          timer_nxt = GUARD_LOAD;
        end else begin
          timer_nxt = timer - TIMER_ONE;
        end
      end
      S_HOLD: begin
        // No timeout here: the barrier must stay up while a vehicle is under it.
        if (!PASS) begin
          state_nxt = S_CLOSE;
          done_nxt  = 1'b1;
          timer_nxt = GUARD_LOAD;
        end
      end
      S_CLOSE: begin
        if (timer == '0) begin
          state_nxt = S_IDLE;
        end else begin
          timer_nxt = timer - TIMER_ONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    gate_nxt = (state_nxt == S_OPEN) || (state_nxt == S_HOLD);
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      timer     <= '0;
      last_dir  <= 1'b1;
      DIR       <= 1'b0;
      GATE_OPEN <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ABORT     <= 1'b0;
      FREE      <= 4'd0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      last_dir  <= last_dir_nxt;
      DIR       <= dir_nxt;
      GATE_OPEN <= gate_nxt;
      BUSY      <= busy_nxt;
      DONE      <= done_nxt;
      ABORT     <= abort_nxt;
      FREE      <= free_nxt;
    end
  end

endmodule
